// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU share arbiter.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam int ID_W    = 1;
  localparam int DEF_OPW = 4;

  function automatic logic [ID_W-1:0] other_id(input logic [ID_W-1:0] id);
    return ~id;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way arbiter with round-robin pointer; define ALU_ARB_FIXED_PRIO_EN for
// fixed priority (requester 0 wins ties, no pointer state).
module rr_arbiter2 import alu_arb_pkg::*; (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req,
  input  logic            adv,
  output logic [1:0]      gnt,
  output logic [ID_W-1:0] gnt_id
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_ok;
  assign unused_ok = ^{clk, rst, adv};
  assign gnt_id    = req[0] ? 1'b0 : 1'b1;
`else
  logic [ID_W-1:0] ptr;

  always_comb begin
    gnt_id = req[0] ? 1'b0 : 1'b1;
    if (req[0] && req[1]) gnt_id = ptr;
  end

  // Pointer always moves to the id that lost (or was absent) this grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                ptr <= '0;
    else if (adv && (|req)) ptr <= other_id(gnt_id);
  end
`endif

  assign gnt = (|req) ? (gnt_id[0] ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters: grant, issue, wait ALU_LAT, respond.
// Arbitration policy selected in rr_arbiter2 via ALU_ARB_FIXED_PRIO_EN.
module alu_share_arbiter import alu_arb_pkg::*; #(
  parameter int N       = 8,
  parameter int OPW     = DEF_OPW,
  parameter int ALU_LAT = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [N-1:0]   req0_a,
  input  logic [N-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [N-1:0]   req1_a,
  input  logic [N-1:0]   req1_b,
  output logic [OPW-1:0] alu_op,
  output logic [N-1:0]   alu_a,
  output logic [N-1:0]   alu_b,
  input  logic [N-1:0]   alu_res,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [N-1:0]   rsp_data
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0] LAT_LOAD = CW'((ALU_LAT > 0) ? ALU_LAT - 1 : 0);

  arb_state_e      state, state_nx;
  logic [CW-1:0]   cnt;
  logic [1:0]      gnt;
  logic [ID_W-1:0] gnt_id, cur_id;
  logic [OPW-1:0]  op_q;
  logic [N-1:0]    a_q, b_q;
  logic            accept, res_latch;

  // Ready is gated by rst so nothing looks accepted while reset is held.
  assign accept = (state == ST_IDLE) && !rst && (req0_valid || req1_valid);

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({req1_valid, req0_valid}),
    .adv    (accept),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req0_ready = accept & gnt[0];
  assign req1_ready = accept & gnt[1];

  always_comb begin
    state_nx  = state;
    res_latch = 1'b0;
    case (state)
      ST_IDLE:  if (accept) state_nx = ST_ISSUE;
      ST_ISSUE: begin
        if (ALU_LAT == 0) begin
          res_latch = 1'b1;
          state_nx  = ST_RESP;
        end else begin
          state_nx  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          res_latch = 1'b1;
          state_nx  = ST_RESP;
        end
      end
      ST_RESP:  if (rsp_ready) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Operand regs feed the ALU directly and only change on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cur_id <= '0;
    end else if (accept) begin
      cur_id <= gnt_id;
      op_q   <= gnt[1] ? req1_op : req0_op;
      a_q    <= gnt[1] ? req1_a  : req0_a;
      b_q    <= gnt[1] ? req1_b  : req0_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (state == ST_ISSUE) cnt <= LAT_LOAD;
    else if (state == ST_WAIT)  cnt <= cnt - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_data <= '0;
      rsp_id   <= 1'b0;
    end else if (res_latch) begin
      rsp_data <= alu_res;
      rsp_id   <= cur_id[0];
    end
  end

  assign rsp_valid = (state == ST_RESP);
  assign alu_op    = op_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: ALU_LAT=0 instance (a_*) and ALU_LAT=3 instance (b_*).
module tb_alu_share_arbiter;

  localparam int N   = 8;
  localparam int OPW = 4;
  localparam logic [OPW-1:0] OP_AND = 4'd0, OP_OR = 4'd1, OP_NOR = 4'd2,
                             OP_ADD = 4'd3, OP_SUB = 4'd4, OP_XOR = 4'd5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [N-1:0] alu_f(input logic [OPW-1:0] op,
                                         input logic [N-1:0] a, input logic [N-1:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_NOR:  return ~(a | b);
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_XOR:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---- instance A: ALU_LAT=0, combinational ALU model
  logic           a_r0v, a_r0r, a_r1v, a_r1r, a_rv, a_rr, a_rid;
  logic [OPW-1:0] a_r0op, a_r1op, a_aop;
  logic [N-1:0]   a_r0a, a_r0b, a_r1a, a_r1b, a_aa, a_ab, a_ares, a_rd;
  assign a_ares = alu_f(a_aop, a_aa, a_ab);

  alu_share_arbiter #(.N(N), .OPW(OPW), .ALU_LAT(0)) u_dut_a (
    .clk(clk), .rst(rst),
    .req0_valid(a_r0v), .req0_ready(a_r0r), .req0_op(a_r0op), .req0_a(a_r0a), .req0_b(a_r0b),
    .req1_valid(a_r1v), .req1_ready(a_r1r), .req1_op(a_r1op), .req1_a(a_r1a), .req1_b(a_r1b),
    .alu_op(a_aop), .alu_a(a_aa), .alu_b(a_ab), .alu_res(a_ares),
    .rsp_valid(a_rv), .rsp_ready(a_rr), .rsp_id(a_rid), .rsp_data(a_rd)
  );

  // ---- instance B: ALU_LAT=3, three-stage pipelined ALU model
  logic           b_r0v, b_r0r, b_r1v, b_r1r, b_rv, b_rr, b_rid;
  logic [OPW-1:0] b_r0op, b_r1op, b_aop;
  logic [N-1:0]   b_r0a, b_r0b, b_r1a, b_r1b, b_aa, b_ab, b_ares, b_rd;
  logic [N-1:0]   b_pipe [3] = '{default: '0};
  always @(posedge clk) begin
    b_pipe[0] <= alu_f(b_aop, b_aa, b_ab);
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign b_ares = b_pipe[2];

  alu_share_arbiter #(.N(N), .OPW(OPW), .ALU_LAT(3)) u_dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(b_r0v), .req0_ready(b_r0r), .req0_op(b_r0op), .req0_a(b_r0a), .req0_b(b_r0b),
    .req1_valid(b_r1v), .req1_ready(b_r1r), .req1_op(b_r1op), .req1_a(b_r1a), .req1_b(b_r1b),
    .alu_op(b_aop), .alu_a(b_aa), .alu_b(b_ab), .alu_res(b_ares),
    .rsp_valid(b_rv), .rsp_ready(b_rr), .rsp_id(b_rid), .rsp_data(b_rd)
  );

  logic         exp_ord [4];
  logic         gid;
  logic [N-1:0] exp_d;
  int           w, lat;

  initial begin
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_ord = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_ord = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    {a_r0v, a_r1v, b_r0v, b_r1v} = '0;
    {a_r0op, a_r1op, b_r0op, b_r1op} = '0;
    {a_r0a, a_r0b, a_r1a, a_r1b} = '0;
    {b_r0a, b_r0b, b_r1a, b_r1b} = '0;
    a_rr = 1'b1;
    b_rr = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_a_rv",  a_rv, 0);
    chk("rst_a_rsp", {a_rid, a_rd}, 0);
    chk("rst_a_alu", {a_aop, a_aa, a_ab}, 0);
    chk("rst_b_rv",  b_rv, 0);
    chk("rst_b_alu", {b_aop, b_aa, b_ab}, 0);
    rst = 1'b0;

    // single NOR from requester 0
    @(negedge clk);
    a_r0v = 1'b1; a_r0op = OP_NOR; a_r0a = 8'hF0; a_r0b = 8'h0F; #1;
    chk("nor_ready0", a_r0r, 1);
    chk("nor_ready1", a_r1r, 0);
    @(negedge clk);
    a_r0v = 1'b0; #1;
    chk("nor_ready_once", a_r0r, 0);
    chk("nor_alu_bus", {a_aop, a_aa, a_ab}, {OP_NOR, 8'hF0, 8'h0F});
    chk("nor_rv_issue", a_rv, 0);
    @(negedge clk);
    chk("nor_rv", a_rv, 1);
    chk("nor_id", a_rid, 0);
    chk("nor_data", a_rd, 8'h00);
    @(negedge clk);
    chk("nor_rv_drop", a_rv, 0);

    // reset asserted mid-ISSUE, req0 still pending
    a_r0v = 1'b1; a_r0op = OP_ADD; a_r0a = 8'h11; a_r0b = 8'h22; #1;
    chk("rm_accept", a_r0r, 1);
    @(negedge clk);
    rst = 1'b1; #1;
    chk("rm_ready0", a_r0r, 0);
    chk("rm_rv", a_rv, 0);
    chk("rm_rsp", {a_rid, a_rd}, 0);
    chk("rm_alu", {a_aop, a_aa, a_ab}, 0);
    @(negedge clk);
    a_r0v = 1'b0; rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("rm_no_rsp", a_rv, 0);
    end

    // both requesters valid every cycle, four ops
    a_r0v = 1'b1; a_r0op = OP_ADD; a_r0a = 8'hFF; a_r0b = 8'h01;
    a_r1v = 1'b1; a_r1op = OP_XOR; a_r1a = 8'hA5; a_r1b = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      w = 0; #1;
      while (!(a_r0r || a_r1r) && w < 10) begin
        @(negedge clk); #1; w++;
      end
      chk("rr_wait_grant", (w < 10), 1);
      chk("rr_onehot", (a_r0r & a_r1r), 0);
      gid   = a_r1r;
      exp_d = gid ? alu_f(a_r1op, a_r1a, a_r1b) : alu_f(a_r0op, a_r0a, a_r0b);
      chk("rr_grant_order", gid, exp_ord[k]);
      @(negedge clk);
      if (gid) a_r1a = a_r1a + 8'h13;
      else     a_r0a = a_r0a + 8'h13;
      @(negedge clk);
      chk("rr_rv", a_rv, 1);
      chk("rr_rsp_id", a_rid, gid);
      chk("rr_rsp_data", a_rd, exp_d);
      if (k == 3) begin a_r0v = 1'b0; a_r1v = 1'b0; end
      @(negedge clk);
    end

    // requester 0 raises then drops valid while busy; requester 1 served
    a_r1v = 1'b1; a_r1op = OP_OR; a_r1a = 8'h0C; a_r1b = 8'h30; #1;
    chk("drop_acc1", a_r1r, 1);
    @(negedge clk);
    a_r1v = 1'b0; a_r0v = 1'b1; a_r0op = OP_AND; a_r0a = 8'hFF; a_r0b = 8'hFF; a_rr = 1'b0; #1;
    chk("drop_busy_r0", a_r0r, 0);
    @(negedge clk);
    chk("drop_resp_r0", a_r0r, 0);
    chk("drop_rv", a_rv, 1);
    chk("drop_id", a_rid, 1);
    chk("drop_data", a_rd, 8'h3C);
    a_r0v = 1'b0; a_rr = 1'b1;
    repeat (4) begin
      @(negedge clk); #1;
      chk("drop_no_rsp", a_rv, 0);
      chk("drop_no_acc", a_r0r, 0);
    end

    // ALU_LAT=3: requester 1 ADD, response exactly 5 cycles after accept
    b_r1v = 1'b1; b_r1op = OP_ADD; b_r1a = 8'h7F; b_r1b = 8'h03; b_rr = 1'b0; #1;
    chk("l3_acc", b_r1r, 1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        b_r1v = 1'b0; b_r0v = 1'b1; b_r0op = OP_SUB; b_r0a = 8'h10; b_r0b = 8'h20;
      end
      #1;
      chk("l3_rv_timing", b_rv, (c == 5));
      chk("l3_alu_stable", {b_aop, b_aa, b_ab}, {OP_ADD, 8'h7F, 8'h03});
      chk("l3_busy_r0", b_r0r, 0);
    end
    chk("l3_id", b_rid, 1);
    chk("l3_data", b_rd, 8'h82);

    // backpressure: rsp_ready low for six more cycles
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      chk("bp_rv", b_rv, 1);
      chk("bp_rsp", {b_rid, b_rd}, {1'b1, 8'h82});
      chk("bp_ready", {b_r0r, b_r1r}, 0);
    end
    b_rr = 1'b1;
    @(negedge clk); #1;
    chk("bp_release_rv", b_rv, 0);
    chk("bp_idle_accept", b_r0r, 1);
    @(negedge clk);
    b_r0v = 1'b0;
    lat = 1;
    while (!b_rv && lat < 12) begin
      @(negedge clk); lat++;
    end
    chk("l3_latency2", lat, 5);
    chk("l3_id2", b_rid, 0);
    chk("l3_data2", b_rd, 8'hF0);
    @(negedge clk);
    chk("l3_rv_drop", b_rv, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
